// File: rtl/snn_step_scheduler.sv
// Run-level sequencer for the spiking network: replays queued forced spikes per step,
// pulses time_step, then waits for the output stream to stay idle for QUIET cycles.
module snn_step_scheduler #(
    parameter int unsigned TA     = 4,
    parameter int unsigned NW     = 4,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned QUIET  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              stim_valid,
    output logic              stim_ready,
    input  logic [TA-1:0]     stim_block,
    input  logic [NW-1:0]     stim_neuron,
    input  logic [STEP_W-1:0] stim_step,
    output logic              force_spike_en,
    output logic [TA-1:0]     force_spike_block_select,
    output logic [NW-1:0]     force_spike_neuron_select,
    output logic              time_step,
    input  logic              out_tvalid,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic              stim_dropped
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned QW = $clog2(QUIET + 1);
    localparam int unsigned EW = TA + NW + STEP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INJECT,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [STEP_W-1:0] steps_lat;
    logic [QW-1:0]     quiet_cnt;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              head_due;
    logic              head_stale;
    logic [TA-1:0]     head_block;
    logic [NW-1:0]     head_neuron;
    logic [STEP_W-1:0] head_step;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign stim_ready = !full;
    assign push       = stim_valid && !full;

    assign {head_block, head_neuron, head_step} = mem[rd_ptr];
    assign head_due   = !empty && (head_step == step_count);
    assign head_stale = !empty && (head_step < step_count);
    // abort takes priority over the INJECT decision, so the head entry stays queued
    assign pop        = (state == S_INJECT) && !abort && (head_due || head_stale);

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {stim_block, stim_neuron, stim_step};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                     <= S_IDLE;
            force_spike_en            <= 1'b0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            time_step                 <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            step_count                <= '0;
            stim_dropped              <= 1'b0;
            steps_lat                 <= '0;
            quiet_cnt                 <= '0;
        end else begin
            force_spike_en            <= 1'b0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            time_step                 <= 1'b0;
            done                      <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            busy <= 1'b1;
                            if (num_steps != '0) begin
                                step_count <= '0;
                                steps_lat  <= num_steps;
                                state      <= S_INJECT;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                    S_INJECT: begin
                        if (head_due) begin
                            force_spike_en            <= 1'b1;
                            force_spike_block_select  <= head_block;
                            force_spike_neuron_select <= head_neuron;
                        end else if (head_stale) begin
                            stim_dropped <= 1'b1;
                        end else begin
                            time_step <= 1'b1;
                            state     <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        quiet_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (quiet_cnt == QW'(QUIET)) begin
                            if (step_count == steps_lat - 1'b1) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                step_count <= step_count + 1'b1;
                                state      <= S_INJECT;
                            end
                        end else if (out_tvalid) begin
                            quiet_cnt <= '0;
                        end else begin
                            quiet_cnt <= quiet_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: event cycles are logged at negedge and
// compared against hand-computed cycle offsets from each run's start.
module tb_snn_step_scheduler;
    localparam int unsigned TA     = 4;
    localparam int unsigned NW     = 4;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned QUIET  = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] num_steps;
    logic              stim_valid;
    logic              stim_ready;
    logic [TA-1:0]     stim_block;
    logic [NW-1:0]     stim_neuron;
    logic [STEP_W-1:0] stim_step;
    logic              force_spike_en;
    logic [TA-1:0]     force_spike_block_select;
    logic [NW-1:0]     force_spike_neuron_select;
    logic              time_step;
    logic              out_tvalid;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_count;
    logic              stim_dropped;

    snn_step_scheduler #(
        .TA(TA), .NW(NW), .STEP_W(STEP_W), .DEPTH(DEPTH), .QUIET(QUIET)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .num_steps(num_steps), .stim_valid(stim_valid), .stim_ready(stim_ready),
        .stim_block(stim_block), .stim_neuron(stim_neuron), .stim_step(stim_step),
        .force_spike_en(force_spike_en),
        .force_spike_block_select(force_spike_block_select),
        .force_spike_neuron_select(force_spike_neuron_select),
        .time_step(time_step), .out_tvalid(out_tvalid), .busy(busy), .done(done),
        .step_count(step_count), .stim_dropped(stim_dropped)
    );

    always #5 aclk = ~aclk;

    int unsigned       cyc = 0;
    int unsigned       ts_q[$];
    int unsigned       fs_cyc[$];
    logic [TA+NW-1:0]  fs_sel[$];
    int unsigned       done_q[$];
    int unsigned       viol = 0;
    int                checks = 0;
    int                failures = 0;
    int unsigned       s;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (time_step) ts_q.push_back(cyc);
        if (force_spike_en) begin
            fs_cyc.push_back(cyc);
            fs_sel.push_back({force_spike_block_select, force_spike_neuron_select});
        end else if (force_spike_block_select != '0 || force_spike_neuron_select != '0) begin
            viol++;
        end
        if (force_spike_en && time_step) viol++;
        if (done) done_q.push_back(cyc);
    end

    function automatic logic [31:0] ts_at(input int i);
        return (i < ts_q.size()) ? ts_q[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] fs_at(input int i);
        return (i < fs_cyc.size()) ? fs_cyc[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] sel_at(input int i);
        return (i < fs_sel.size()) ? 32'(fs_sel[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        ts_q.delete();
        fs_cyc.delete();
        fs_sel.delete();
        done_q.delete();
    endtask

    task automatic push_entry(input logic [TA-1:0] b, input logic [NW-1:0] n, input logic [STEP_W-1:0] st);
        stim_valid  = 1'b1;
        stim_block  = b;
        stim_neuron = n;
        stim_step   = st;
        tick();
        stim_valid  = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; num_steps = '0;
        stim_valid = 1'b0; stim_block = '0; stim_neuron = '0; stim_step = '0;
        out_tvalid = 1'b0;
        tick(3);
        chk("rst_outputs", {force_spike_en, time_step, busy, done, stim_dropped}, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_stim_ready", stim_ready, 1);
        aresetn = 1'b1;
        tick();

        // empty FIFO, three steps, quiet output
        clear_mon();
        num_steps = 3; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        chk("t1_busy", busy, 1);
        tick(40);
        chk("t1_ts_count", ts_q.size(), 3);
        chk("t1_ts0", ts_at(0), s + 2);
        chk("t1_ts1", ts_at(1), s + 2 + (QUIET + 3));
        chk("t1_ts2", ts_at(2), s + 2 + 2 * (QUIET + 3));
        chk("t1_done_count", done_q.size(), 1);
        chk("t1_done_cyc", done_at(0), s + 34);
        chk("t1_step_count", step_count, 2);
        chk("t1_busy_end", busy, 0);

        // forced spikes replayed before their steps
        clear_mon();
        push_entry(4'd1, 4'd2, 16'd0);
        push_entry(4'd3, 4'd5, 16'd0);
        push_entry(4'd0, 4'd1, 16'd2);
        num_steps = 3; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        tick(45);
        chk("t2_fs_count", fs_cyc.size(), 3);
        chk("t2_fs0_cyc", fs_at(0), s + 2);
        chk("t2_fs0_sel", sel_at(0), 32'h12);
        chk("t2_fs1_cyc", fs_at(1), s + 3);
        chk("t2_fs1_sel", sel_at(1), 32'h35);
        chk("t2_fs2_cyc", fs_at(2), s + 26);
        chk("t2_fs2_sel", sel_at(2), 32'h01);
        chk("t2_ts0", ts_at(0), s + 4);
        chk("t2_ts1", ts_at(1), s + 15);
        chk("t2_ts2", ts_at(2), s + 27);
        chk("t2_done_cyc", done_at(0), s + 37);

        // activity every QUIET-1 cycles holds the step open
        clear_mon();
        num_steps = 1; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        tick();
        chk("t3_latency", time_step, 1);
        tick();
        for (int i = 0; i < 40; i++) begin
            out_tvalid = ((i % (QUIET - 1)) == 0);
            tick();
        end
        out_tvalid = 1'b0;
        chk("t3_still_busy", busy, 1);
        chk("t3_no_done_yet", done_q.size(), 0);
        tick(10);
        chk("t3_done_cyc", done_at(0), s + 48);
        chk("t3_ts_count", ts_q.size(), 1);

        // FIFO full back-pressure
        clear_mon();
        for (int i = 1; i <= 16; i++) begin
            stim_valid = 1'b1; stim_block = i[3:0]; stim_neuron = i[4:1]; stim_step = '0;
            tick();
            chk("t4_ready_fill", stim_ready, (i < 16) ? 1 : 0);
        end
        stim_block = 4'd1; stim_neuron = 4'd8; stim_step = '0;
        tick(2);
        chk("t4_ready_held", stim_ready, 0);
        num_steps = 1; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        chk("t4_ready_before_pop", stim_ready, 0);
        tick();
        chk("t4_ready_after_pop", stim_ready, 1);
        tick(); stim_valid = 1'b0;
        tick(30);
        chk("t4_fs_count", fs_cyc.size(), 17);
        chk("t4_fs_first_cyc", fs_at(0), s + 2);
        chk("t4_fs_first_sel", sel_at(0), 32'h10);
        chk("t4_fs_last_cyc", fs_at(16), s + 18);
        chk("t4_fs_last_sel", sel_at(16), 32'h18);
        chk("t4_ts0", ts_at(0), s + 19);
        chk("t4_done_cyc", done_at(0), s + 29);

        // stale entry dropped, then abort mid-DRAIN
        clear_mon();
        num_steps = 3; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        tick(14);
        push_entry(4'd5, 4'd6, 16'd0);
        chk("t5_dropped_pre", stim_dropped, 0);
        tick(7);
        chk("t5_step_count", step_count, 2);
        chk("t5_dropped_not_yet", stim_dropped, 0);
        tick();
        chk("t5_dropped_set", stim_dropped, 1);
        tick(4);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        tick(20);
        chk("t5_no_done", done_q.size(), 0);
        chk("t5_no_fs", fs_cyc.size(), 0);
        chk("t5_ts_count", ts_q.size(), 3);
        chk("t5_ts2", ts_at(2), s + 25);
        chk("t5_dropped_sticky", stim_dropped, 1);

        // abort beats start in IDLE
        num_steps = 2; start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        chk("t5_abort_start_busy", busy, 0);
        chk("t5_abort_start_cnt", step_count, 2);

        // zero-length run goes straight to DONE
        clear_mon();
        num_steps = 0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t0_done", done, 1);
        chk("t0_busy", busy, 1);
        chk("t0_step_count", step_count, 2);
        tick();
        chk("t0_done_clear", done, 0);
        chk("t0_busy_clear", busy, 0);
        tick(5);
        chk("t0_no_ts", ts_q.size(), 0);

        // reset mid-INJECT clears outputs and FIFO
        clear_mon();
        push_entry(4'd2, 4'd3, 16'd1);
        push_entry(4'd4, 4'd4, 16'd1);
        num_steps = 2; start = 1'b1;
        tick(); start = 1'b0;
        tick(12);
        chk("t6_pre_en", force_spike_en, 1);
        chk("t6_pre_sel", {force_spike_block_select, force_spike_neuron_select}, 32'h23);
        chk("t6_pre_step", step_count, 1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_outputs", {force_spike_en, force_spike_block_select, force_spike_neuron_select,
                               time_step, busy, done, stim_dropped}, 0);
        chk("t6_rst_step", step_count, 0);
        chk("t6_rst_ready", stim_ready, 1);
        tick(2);
        aresetn = 1'b1;
        tick();
        clear_mon();
        num_steps = 2; start = 1'b1; s = cyc;
        tick(); start = 1'b0;
        tick(30);
        chk("t6_no_fs", fs_cyc.size(), 0);
        chk("t6_ts0", ts_at(0), s + 2);
        chk("t6_ts1", ts_at(1), s + 13);
        chk("t6_done_cyc", done_at(0), s + 23);
        chk("t6_step_count", step_count, 1);

        chk("strobe_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snn_step_scheduler.md
# snn_step_scheduler

Run-level sequencer for the spiking network. It accepts a queue of stimulus entries (block, neuron, target step) and runs a fixed number of time steps. For each step it first replays the forced spikes due at that step, then issues one `time_step` pulse, then waits for the network's output AXI-Stream to go quiet before moving on. It drives the network's `force_spike_*` and `time_step` inputs and only monitors the output stream; it does not consume it.

## Interface
Parameters:
- `TA`, 4: width of the block select; matches the network's `force_spike_block_select`.
- `NW`, 4: width of the neuron select; matches `force_spike_neuron_select`.
- `STEP_W`, 16: width of the step counter and of step tags.
- `DEPTH`, 16: stimulus FIFO depth; power of two, at least 2.
- `QUIET`, 8: number of consecutive idle output cycles that ends a step; at least 1.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  stops the run and returns to IDLE.
- `num_steps`  in  STEP_W  number of steps in the run; latched on the accepted `start`.
- `stim_valid`  in  1  stimulus entry valid.
- `stim_ready`  out  1  FIFO can accept an entry; equals `!full`.
- `stim_block`  in  TA  target block of the entry.
- `stim_neuron`  in  NW  target neuron of the entry.
- `stim_step`  in  STEP_W  step index at which the entry fires.
- `force_spike_en`  out  1  forced-spike strobe to the network.
- `force_spike_block_select`  out  TA  block of the forced spike.
- `force_spike_neuron_select`  out  NW  neuron of the forced spike.
- `time_step`  out  1  step-advance pulse to the network.
- `out_tvalid`  in  1  monitor tap of the network's `axis_out` tvalid.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `step_count`  out  STEP_W  index of the current step.
- `stim_dropped`  out  1  sticky flag: a stale entry was discarded.

## Operation
- Stimulus FIFO:
  - An entry is pushed when `stim_valid & stim_ready`.
  - Pushes are accepted in any state.
  - Push and pop in the same cycle are both legal when the FIFO is not full.
  - When full, `stim_ready` is 0 and no push occurs.
  - Entries must be supplied in non-decreasing `stim_step` order; the block does not sort.
- IDLE:
  - `start` with `num_steps != 0`: clear `step_count`, latch `num_steps`, go to INJECT.
  - `start` with `num_steps == 0`: go to DONE.
- INJECT, evaluated on the FIFO head, at most one entry per cycle:
  - head step == `step_count`: pulse `force_spike_en` with the entry's selects, pop, stay in INJECT.
  - head step < `step_count`: pop, set `stim_dropped`, do not force a spike, stay in INJECT.
  - FIFO empty or head step > `step_count`: go to STEP.
- STEP: `time_step` is 1 for exactly one cycle; clear the quiet counter; go to DRAIN.
- DRAIN:
  - Any cycle with `out_tvalid=1` resets the quiet counter to 0; otherwise it increments.
  - When the counter reaches `QUIET`: if `step_count == num_steps_latched-1`, go to DONE; otherwise increment `step_count` and go to INJECT.
- DONE: `done` is 1 for one cycle; go to IDLE. `step_count` holds its final value until the next `start`.
- `abort`:
  - In any non-IDLE state, go to IDLE on the next edge with no `done` pulse.
  - FIFO contents and `stim_dropped` are retained.
  - If `abort` and `start` are both high in IDLE, `abort` wins and the run does not start.
- `start` while `busy` is ignored.
- `stim_dropped` clears only on reset.

## Timing
- All outputs are registered except `stim_ready`, which is combinational from the FIFO count.
- Reset values: state IDLE, FIFO empty, all outputs 0, so `stim_ready=1` while reset is deasserted.
- Asserting reset mid-run clears everything immediately, including the FIFO; no `done`.
- Forced spikes:
  - `force_spike_en` rises in the cycle after the INJECT decision edge.
  - Consecutive matching entries produce back-to-back one-cycle strobes, each with its own selects.
  - Selects are 0 whenever `force_spike_en` is 0.
- Step period, with k entries due at the step: 1 (INJECT exit) + k + 1 (STEP) + at least `QUIET` cycles of DRAIN.
- Latency from `start` to the first `time_step` with an empty FIFO: 2 cycles.
- Never both `force_spike_en` and `time_step` in the same cycle.
- `step_count` is the only counter that wraps; `num_steps` is bounded by `2^STEP_W - 1`, so no wrap within a run.

## Test plan
- Empty FIFO, `num_steps=3`, `out_tvalid=0`: exactly 3 `time_step` pulses spaced `QUIET+3` cycles apart; `done` one cycle after the last DRAIN; `step_count=2`.
- Entries (b1,n2,s0), (b3,n5,s0), (b0,n1,s2), `num_steps=3`: two back-to-back strobes before step 0's `time_step`, one strobe before step 2's; selects match the entries.
- `out_tvalid` pulsed every `QUIET-1` cycles for 40 cycles after `time_step`: no step advance until `QUIET` consecutive idle cycles follow.
- Push 17 entries at `DEPTH=16` while IDLE: `stim_ready` drops after the 16th push and the 17th is held off; it rises again after the first pop.
- Entry with step 0 pushed during step 1's DRAIN: it is popped in the next INJECT with no strobe and `stim_dropped=1`. Then `abort` mid-DRAIN: IDLE next cycle, `busy=0`, no `done`.
- Reset asserted mid-INJECT: all outputs 0 and the FIFO empty within the same cycle; `start` after release begins at `step_count=0`.
